motor_step_driver: RTL and testbench
====================================

# motor_step_driver

Downstream stage of the five-key entry block. It consumes the committed motor select (one-hot) and three-digit BCD target position, and converts the target to binary. It then drives step/direction pulses to the selected motor until that motor's tracked position equals the target. A current position (0–999 steps) is kept for each of the six motors.

## Interface
- `HALF_PERIOD`, default 5000: sysclk cycles of STEP high and of STEP low, 1..65535.
- `DIR_SETUP`, default 8: sysclk cycles Dir is held stable before the first STEP rising edge, 1..255.
- `sysclk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `TValue0`  in  4  target hundreds digit, BCD.
- `TValue1`  in  4  target tens digit, BCD.
- `TValue2`  in  4  target units digit, BCD.
- `Motor`  in  6  one-hot motor select; bit0 = motor 1 … bit5 = motor 6.
- `Step`  out  6  step pulse, only the active motor's bit toggles.
- `Dir`  out  6  direction; 1 = increasing position, valid for the active motor only.
- `Busy`  out  1  high while a move is in progress.
- `Done`  out  1  one-cycle pulse when a move completes.
- `Err`  out  1  one-cycle pulse when a command is rejected.

## Operation
- Commands are detected by change, with no strobe. The block holds a snapshot of {Motor, TValue0..2}, reset to all zeros.
  - In IDLE, if the inputs differ from the snapshot, the snapshot loads the inputs and the command is accepted.
  - Differences are evaluated only in IDLE. A change during a move is picked up after the move returns to IDLE.
  - Intermediate values that change during a move are lost; only the latest value is acted on.
- Validation happens in LOAD. A command is rejected (Err pulse, back to IDLE, no motion, no position change) if either holds:
  - Motor is not exactly one-hot (zero, or more than one bit set);
  - any digit is greater than 9.
- Conversion: target = 100·TValue0 + 10·TValue1 + TValue2, 10-bit unsigned, range 0..999.
- Position store: six 10-bit registers, all 0 on reset.
- States:
  - IDLE: Busy=0.
  - LOAD: index the selected motor, convert the target, compare. Equal → DONE. Greater → Dir bit = 1. Less → Dir bit = 0. Then → SETUP.
  - SETUP: hold Dir for DIR_SETUP cycles → HIGH.
  - HIGH: Step bit = 1 for HALF_PERIOD cycles → LOW.
  - LOW: Step bit = 0 for HALF_PERIOD cycles. At the end of LOW, position ±1. If the new position equals the target → DONE, else → HIGH.
  - DONE: Done = 1 for one cycle → IDLE.
- Dir bits of non-selected motors keep their last value. Step bits of non-selected motors stay 0.
- Position never wraps: the target is at most 999 and the move always heads toward it.

## Timing
- Reset values: Step=0, Dir=0, Busy=0, Done=0, Err=0, positions=0, snapshot=0, state IDLE. No command is issued after reset, since the upstream block also resets to zero.
- Reset asserted mid-move: every output clears immediately (asynchronously) and the position is lost (returns to 0).
- Command change seen in IDLE at edge N: LOAD at N+1, with Busy=1 from N+1 through DONE inclusive.
- Zero-distance move: Done at N+2, no Step activity.
- Move of k steps: first Step rise at N+2+DIR_SETUP. Each step takes 2·HALF_PERIOD cycles. Done is high during the cycle after the final LOW.
- Err pulse: in the cycle after LOAD. Busy is high only during LOAD.

## Configuration
- `HOME_SWITCH_EN`: adds input `Home` [5:0], active-high, one switch per motor.
  - Defined: during LOW with Dir=0, if the selected motor's Home bit is 1 at the end of LOW, that motor's position is forced to 0 and the block goes to DONE, even if the target is not reached.
  - Not defined: the port is absent and moves are counted purely by steps.

## Test plan
All scenarios use HALF_PERIOD=2 and DIR_SETUP=1.
- Reset, then Motor=000001, digits 0,0,3 → Dir[0]=1 and 3 Step[0] pulses each 2 high/2 low. First rise 3 cycles after the change. Done pulse; position of motor 1 = 3.
- Then Motor=000001, digits 0,0,1 → Dir[0]=0 and 2 pulses; position = 1. Same input re-applied → no new command.
- Motor=100000, digits 9,9,9 → 999 Step[5] pulses and Done. Motor-1 position unchanged at 1.
- Motor=000011 or digit=A → Err pulse, no Step activity, Busy high for exactly one cycle.
- Change the digits during a move → the current move completes. A new move toward the latest value starts after IDLE.
- rst asserted mid-pulse → Step/Busy clear in the same cycle and all positions read 0 afterward. With HOME_SWITCH_EN: Home[0]=1 during a downward move → Done early, position 0.

Source files
------------

// File: rtl/motor_step_driver.sv
// Six-motor step/direction driver: converts a committed BCD target and steps the selected motor there.
// Optional HOME_SWITCH_EN adds a per-motor home switch that zeroes the position on a downward move.
module motor_step_driver #(
    parameter int HALF_PERIOD = 5000,
    parameter int DIR_SETUP   = 8
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [3:0] TValue0,
    input  logic [3:0] TValue1,
    input  logic [3:0] TValue2,
    input  logic [5:0] Motor,
`ifdef HOME_SWITCH_EN
    input  logic [5:0] Home,
`endif
    output logic [5:0] Step,
    output logic [5:0] Dir,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);
    // state | meaning
    // IDLE  | waiting for the inputs to differ from the snapshot
    // LOAD  | validate, convert target, compare with current position
    // SETUP | Dir held stable before the first step edge
    // HIGH  | Step high for HALF_PERIOD cycles
    // LOW   | Step low for HALF_PERIOD cycles, position updated at its end
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LOW, DONE} state_t;

    localparam logic [15:0] HP_LD = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] DS_LD = 16'(DIR_SETUP - 1);

    state_t      state, state_nxt;
    logic [17:0] snap;
    logic [17:0] cmd;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx;
    logic [2:0]  sel_idx;
    logic [9:0]  target;
    logic [9:0]  tgt_conv;
    logic [9:0]  pos [6];
    logic [9:0]  step_pos;
    logic [5:0]  dir_q;
    logic [5:0]  m;
    logic        cmd_ok;
    logic        tc;
    logic        home_hit;

    assign cmd = {Motor, TValue0, TValue1, TValue2};
    assign m   = snap[17:12];
    assign tc  = (cnt == 16'd0);

    assign cmd_ok   = (m != 6'd0) && ((m & (m - 6'd1)) == 6'd0) &&
                      (snap[11:8] <= 4'd9) && (snap[7:4] <= 4'd9) && (snap[3:0] <= 4'd9);
    assign tgt_conv = 10'(snap[11:8]) * 10'd100 + 10'(snap[7:4]) * 10'd10 + 10'(snap[3:0]);
    assign step_pos = dir_q[idx] ? pos[idx] + 10'd1 : pos[idx] - 10'd1;

`ifdef HOME_SWITCH_EN
    assign home_hit = !dir_q[idx] && Home[idx];
`else
    assign home_hit = 1'b0;
`endif

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) sel_idx = 3'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = tc ? cnt : cnt - 16'd1;
        case (state)
            IDLE: if (cmd != snap) state_nxt = LOAD;
            LOAD: begin
                if (!cmd_ok)                        state_nxt = IDLE;
                else if (tgt_conv == pos[sel_idx])  state_nxt = DONE;
                else begin
                    state_nxt = SETUP;
                    cnt_nxt   = DS_LD;
                end
            end
            SETUP: if (tc) begin
                state_nxt = HIGH;
                cnt_nxt   = HP_LD;
            end
            HIGH: if (tc) begin
                state_nxt = LOW;
                cnt_nxt   = HP_LD;
            end
            LOW: if (tc) begin
                if (home_hit || step_pos == target) state_nxt = DONE;
                else begin
                    state_nxt = HIGH;
                    cnt_nxt   = HP_LD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            snap   <= 18'd0;
            idx    <= 3'd0;
            target <= 10'd0;
            dir_q  <= 6'd0;
            Err    <= 1'b0;
            for (int i = 0; i < 6; i++) pos[i] <= 10'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Err   <= (state == LOAD) && !cmd_ok;
            if (state == IDLE && cmd != snap) snap <= cmd;
            if (state == LOAD) begin
                idx    <= sel_idx;
                target <= tgt_conv;
                if (cmd_ok && tgt_conv != pos[sel_idx])
                    dir_q[sel_idx] <= (tgt_conv > pos[sel_idx]);
            end
            // a home switch hit overrides step counting and re-zeroes the motor
            if (state == LOW && tc) pos[idx] <= home_hit ? 10'd0 : step_pos;
        end
    end

    assign Step = (state == HIGH) ? (6'd1 << idx) : 6'd0;
    assign Dir  = dir_q;
    assign Busy = (state != IDLE);
    assign Done = (state == DONE);
endmodule

// File: tb/tb_motor_step_driver.sv
// Directed bench for motor_step_driver with HALF_PERIOD=2, DIR_SETUP=1; define HOME_SWITCH_EN to cover Home.
module tb_motor_step_driver;
    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] TValue0 = 4'd0, TValue1 = 4'd0, TValue2 = 4'd0;
    logic [5:0] Motor = 6'd0;
    logic [5:0] Step, Dir;
    logic       Busy, Done, Err;
`ifdef HOME_SWITCH_EN
    logic [5:0] Home = 6'd0;
`endif

    int errors = 0;
    int checks = 0;

    int   r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw;
    logic r_dir;

    always #5 sysclk = ~sysclk;

    motor_step_driver #(.HALF_PERIOD(2), .DIR_SETUP(1)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .TValue0(TValue0),
        .TValue1(TValue1),
        .TValue2(TValue2),
        .Motor  (Motor),
`ifdef HOME_SWITCH_EN
        .Home   (Home),
`endif
        .Step   (Step),
        .Dir    (Dir),
        .Busy   (Busy),
        .Done   (Done),
        .Err    (Err)
    );

    // Drives a command at a falling edge and observes one sample per following falling edge.
    task automatic run_cmd(input logic [5:0] mm, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input int budget, input int chg_at,
                           input logic [3:0] ca, input logic [3:0] cb, input logic [3:0] cc,
                           output int rises, output int first_rise, output int done_at,
                           output int err_at, output int busy_n, output int stray,
                           output int bad_w, output logic dir_r);
        logic prev, cur;
        int   run_h, run_l;
        Motor = mm; TValue0 = a; TValue1 = b; TValue2 = c;
        rises = 0; first_rise = -1; done_at = -1; err_at = -1; busy_n = 0; stray = 0; bad_w = 0;
        dir_r = 1'bx; prev = 1'b0; run_h = 0; run_l = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge sysclk);
            cur = |(Step & mm);
            if ((Step & ~mm) != 6'd0) stray++;
            if (cur && !prev) begin
                rises++;
                if (first_rise < 0) begin
                    first_rise = i;
                    dir_r = |(Dir & mm);
                end
                if (rises > 1 && run_l != 2) bad_w++;
                run_l = 0;
            end
            if (!cur && prev) begin
                if (run_h != 2) bad_w++;
                run_h = 0;
            end
            if (cur) run_h++; else run_l++;
            prev = cur;
            if (Busy) busy_n++;
            if (Done && done_at < 0) done_at = i;
            if (Err && err_at < 0) err_at = i;
            if (i == chg_at) begin
                TValue0 = ca; TValue1 = cb; TValue2 = cc;
            end
            if (done_at > 0 || err_at > 0) break;
        end
        if (done_at > 0 || err_at > 0) @(negedge sysclk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sysclk);
        checks++; if (Step !== 6'd0) begin errors++; $display("FAIL reset_step got=%b exp=000000", Step); end
        checks++; if (Dir !== 6'd0) begin errors++; $display("FAIL reset_dir got=%b exp=000000", Dir); end
        checks++; if ({Busy, Done, Err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {Busy, Done, Err}); end
        rst = 1'b0;
        run_cmd(6'd0, 4'd0, 4'd0, 4'd0, 6, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_busy !== 0) begin errors++; $display("FAIL idle_after_reset busy_cycles=%0d exp=0", r_busy); end
    endtask

    task automatic test_up;
        run_cmd(6'b000001, 4'd0, 4'd0, 4'd3, 100, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 3) begin errors++; $display("FAIL up_rises got=%0d exp=3", r_rises); end
        checks++; if (r_first !== 3) begin errors++; $display("FAIL up_first_rise got=%0d exp=3", r_first); end
        checks++; if (r_dir !== 1'b1) begin errors++; $display("FAIL up_dir got=%b exp=1", r_dir); end
        checks++; if (r_done !== 15) begin errors++; $display("FAIL up_done got=%0d exp=15", r_done); end
        checks++; if (r_busy !== 15) begin errors++; $display("FAIL up_busy got=%0d exp=15", r_busy); end
        checks++; if (r_badw !== 0 || r_stray !== 0) begin errors++; $display("FAIL up_shape badw=%0d stray=%0d exp=0,0", r_badw, r_stray); end
    endtask

    task automatic test_down;
        run_cmd(6'b000001, 4'd0, 4'd0, 4'd1, 100, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 2) begin errors++; $display("FAIL down_rises got=%0d exp=2", r_rises); end
        checks++; if (r_dir !== 1'b0) begin errors++; $display("FAIL down_dir got=%b exp=0", r_dir); end
        checks++; if (r_done !== 11) begin errors++; $display("FAIL down_done got=%0d exp=11", r_done); end
        checks++; if (r_badw !== 0) begin errors++; $display("FAIL down_width bad=%0d exp=0", r_badw); end
        run_cmd(6'b000001, 4'd0, 4'd0, 4'd1, 10, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_busy !== 0 || r_done !== -1) begin errors++; $display("FAIL reapply busy=%0d done=%0d exp=0,-1", r_busy, r_done); end
    endtask

    task automatic test_far;
        run_cmd(6'b100000, 4'd9, 4'd9, 4'd9, 4200, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 999) begin errors++; $display("FAIL far_rises got=%0d exp=999", r_rises); end
        checks++; if (r_done !== 3999) begin errors++; $display("FAIL far_done got=%0d exp=3999", r_done); end
        checks++; if (r_dir !== 1'b1) begin errors++; $display("FAIL far_dir got=%b exp=1", r_dir); end
        checks++; if (r_badw !== 0 || r_stray !== 0) begin errors++; $display("FAIL far_shape badw=%0d stray=%0d exp=0,0", r_badw, r_stray); end
        run_cmd(6'b000001, 4'd0, 4'd0, 4'd1, 20, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_done !== 2 || r_rises !== 0) begin errors++; $display("FAIL m1_kept done=%0d rises=%0d exp=2,0", r_done, r_rises); end
        checks++; if (r_busy !== 2) begin errors++; $display("FAIL zero_busy got=%0d exp=2", r_busy); end
    endtask

    task automatic test_err;
        run_cmd(6'b000011, 4'd0, 4'd0, 4'd5, 20, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_err !== 2) begin errors++; $display("FAIL err_twohot_at got=%0d exp=2", r_err); end
        checks++; if (r_busy !== 1 || r_rises !== 0 || r_stray !== 0) begin errors++; $display("FAIL err_twohot busy=%0d rises=%0d stray=%0d exp=1,0,0", r_busy, r_rises, r_stray); end
        run_cmd(6'b000001, 4'd0, 4'd0, 4'hA, 20, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_err !== 2) begin errors++; $display("FAIL err_digit_at got=%0d exp=2", r_err); end
        checks++; if (r_busy !== 1 || r_rises !== 0 || r_done !== -1) begin errors++; $display("FAIL err_digit busy=%0d rises=%0d done=%0d exp=1,0,-1", r_busy, r_rises, r_done); end
        run_cmd(6'b000001, 4'd0, 4'd0, 4'd2, 40, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 1 || r_dir !== 1'b1) begin errors++; $display("FAIL err_pos_kept rises=%0d dir=%b exp=1,1", r_rises, r_dir); end
    endtask

    task automatic test_back_to_back;
        run_cmd(6'b000010, 4'd0, 4'd0, 4'd5, 100, 6, 4'd0, 4'd0, 4'd4,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 5 || r_done !== 23) begin errors++; $display("FAIL chg_first rises=%0d done=%0d exp=5,23", r_rises, r_done); end
        run_cmd(6'b000010, 4'd0, 4'd0, 4'd4, 40, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 1 || r_dir !== 1'b0) begin errors++; $display("FAIL chg_second rises=%0d dir=%b exp=1,0", r_rises, r_dir); end
        checks++; if (r_done !== 7) begin errors++; $display("FAIL chg_second_done got=%0d exp=7", r_done); end
    endtask

    task automatic test_reset_mid;
        Motor = 6'b000001; TValue0 = 4'd0; TValue1 = 4'd0; TValue2 = 4'd9;
        repeat (7) @(negedge sysclk);
        checks++; if (Step !== 6'b000001) begin errors++; $display("FAIL pre_reset_step got=%b exp=000001", Step); end
        rst = 1'b1;
        #1;
        checks++; if (Step !== 6'd0 || Busy !== 1'b0) begin errors++; $display("FAIL async_reset step=%b busy=%b exp=000000,0", Step, Busy); end
        checks++; if (Dir !== 6'd0 || Done !== 1'b0) begin errors++; $display("FAIL async_reset dir=%b done=%b exp=000000,0", Dir, Done); end
        @(negedge sysclk);
        rst = 1'b0;
        run_cmd(6'b000001, 4'd0, 4'd0, 4'd9, 100, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 9 || r_done !== 39) begin errors++; $display("FAIL m1_zeroed rises=%0d done=%0d exp=9,39", r_rises, r_done); end
        run_cmd(6'b100000, 4'd0, 4'd0, 4'd1, 40, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 1 || r_dir !== 1'b1) begin errors++; $display("FAIL m6_zeroed rises=%0d dir=%b exp=1,1", r_rises, r_dir); end
        run_cmd(6'b000010, 4'd0, 4'd0, 4'd0, 40, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 0 || r_done !== 2) begin errors++; $display("FAIL m2_zeroed rises=%0d done=%0d exp=0,2", r_rises, r_done); end
    endtask

`ifdef HOME_SWITCH_EN
    task automatic test_home;
        Home = 6'b000001;
        run_cmd(6'b000001, 4'd0, 4'd0, 4'd3, 100, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 1 || r_done !== 7 || r_dir !== 1'b0) begin errors++; $display("FAIL home_stop rises=%0d done=%0d dir=%b exp=1,7,0", r_rises, r_done, r_dir); end
        Home = 6'b000000;
        run_cmd(6'b000001, 4'd0, 4'd0, 4'd2, 100, 0, 4'd0, 4'd0, 4'd0,
                r_rises, r_first, r_done, r_err, r_busy, r_stray, r_badw, r_dir);
        checks++; if (r_rises !== 2 || r_dir !== 1'b1) begin errors++; $display("FAIL home_zeroed rises=%0d dir=%b exp=2,1", r_rises, r_dir); end
    endtask
`endif

    initial begin
        test_reset;
        test_up;
        test_down;
        test_far;
        test_err;
        test_back_to_back;
        test_reset_mid;
`ifdef HOME_SWITCH_EN
        test_home;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
